// File: rtl/sipo_frame_ctrl_if.sv
// Serial-in / parallel-out frame controller bus.
// Serial input side, flush control and parallel output handshake.
interface sipo_frame_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             sin_valid;
   logic             sin_data;
   logic             sin_ready;
   logic             flush;
   logic [WIDTH-1:0] par_data;
   logic             par_valid;
   logic             par_ready;
   logic             busy;

   modport master (
      output sin_valid,
      output sin_data,
      output flush,
      output par_ready,
      input  sin_ready,
      input  par_data,
      input  par_valid,
      input  busy
   );

   modport slave (
      input  sin_valid,
      input  sin_data,
      input  flush,
      input  par_ready,
      output sin_ready,
      output par_data,
      output par_valid,
      output busy
   );
endinterface

// File: rtl/sipo_frame_ctrl.sv
// Serial-to-parallel frame assembler with a one-deep holding register.
// Bits enter at bit 0; a completed frame waits in FULL if the holder is busy.
module sipo_frame_ctrl #(
   parameter int WIDTH = 4
) (
   input logic              clk,
   input logic              rst_n,
   sipo_frame_ctrl_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      FULL
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;
   logic [WIDTH-1:0] sreg_q;
   logic [WIDTH-1:0] sreg_d;
   logic [WIDTH-1:0] hold_q;
   logic [WIDTH-1:0] hold_d;
   logic             pvalid_q;
   logic             pvalid_d;
   logic             accept;
   logic             last;
   logic             taken;
   logic             hold_free;
   logic             load;

   assign bus.sin_ready = (state_q != FULL);
   assign bus.busy      = (state_q != IDLE);
   assign bus.par_data  = hold_q;
   assign bus.par_valid = pvalid_q;

   always_comb begin
      taken     = pvalid_q && bus.par_ready;
      hold_free = !pvalid_q || taken;
      accept    = bus.sin_valid && (state_q != FULL) && !bus.flush;
      last      = accept && (cnt_q == CNT_LAST);
      state_d   = state_q;
      cnt_d     = cnt_q;
      sreg_d    = sreg_q;
      hold_d    = hold_q;
      pvalid_d  = pvalid_q && !bus.par_ready;
      load      = 1'b0;

      if (accept) begin
         sreg_d = {sreg_q[WIDTH-2:0], bus.sin_data};
         cnt_d  = last ? '0 : cnt_q + CW'(1);
      end

      case (state_q)
         IDLE: begin
            if (accept) state_d = SHIFT;
         end
         SHIFT: begin
            if (last) begin
               if (hold_free) begin
                  load    = 1'b1;
                  hold_d  = sreg_d;
                  state_d = IDLE;
               end else begin
                  state_d = FULL;
               end
            end
         end
         FULL: begin
            if (hold_free) begin
               load    = 1'b1;
               hold_d  = sreg_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Flush beats both a new bit and a pending FULL->holder move
      if (bus.flush) begin
         state_d = IDLE;
         cnt_d   = '0;
         sreg_d  = '0;
         hold_d  = hold_q;
         load    = 1'b0;
      end

      if (load) pvalid_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         sreg_q   <= '0;
         hold_q   <= '0;
         pvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sreg_q   <= sreg_d;
         hold_q   <= hold_d;
         pvalid_q <= pvalid_d;
      end
   end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl with a frame scoreboard.
// Expected frames are queued as driven and matched on each transfer.
module tb_sipo_frame_ctrl;

   localparam int WIDTH = 4;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   logic [WIDTH-1:0] sb[$];
   logic [WIDTH-1:0] exp_f;

   sipo_frame_ctrl_if #(.WIDTH(WIDTH)) bus ();

   sipo_frame_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.sin_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic bit_in(input logic d);
      bus.sin_valid = 1'b1;
      bus.sin_data  = d;
      @(posedge clk);
      #1;
      bus.sin_valid = 1'b0;
   endtask

   // gaps: idle cycles after bit k of the frame equal to k+1
   task automatic send(input logic [WIDTH-1:0] f, input bit gaps);
      sb.push_back(f);
      for (int i = WIDTH - 1; i >= 0; i--) begin
         bit_in(f[i]);
         if (gaps && i > 0) repeat (WIDTH - i) idle();
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.par_valid && bus.par_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL extra_frame: observed %b expected none",
                   bus.par_data);
         end else begin
            exp_f = sb.pop_front();
            chk("frame_data", 32'(bus.par_data), 32'(exp_f));
         end
      end
   end

   initial begin
      checks        = 0;
      errors        = 0;
      rst_n         = 1'b0;
      bus.sin_valid = 1'b0;
      bus.sin_data  = 1'b0;
      bus.flush     = 1'b0;
      bus.par_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_par_valid", 32'(bus.par_valid), 0);
      chk("rst_par_data", 32'(bus.par_data), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_sin_ready", 32'(bus.sin_ready), 1);
      rst_n = 1'b1;
      idle();

      // basic frame 1011
      sb.push_back(4'b1011);
      bit_in(1'b1);
      bit_in(1'b0);
      bit_in(1'b1);
      chk("basic_busy", 32'(bus.busy), 1);
      chk("basic_early_valid", 32'(bus.par_valid), 0);
      bit_in(1'b1);
      chk("basic_valid", 32'(bus.par_valid), 1);
      chk("basic_data", 32'(bus.par_data), 32'h0000000b);
      idle();
      chk("basic_one_cycle", 32'(bus.par_valid), 0);

      // backpressure: second frame parks in FULL
      bus.par_ready = 1'b0;
      send(4'b1011, 1'b0);
      send(4'b0110, 1'b0);
      chk("bp_sin_ready", 32'(bus.sin_ready), 0);
      chk("bp_hold_data", 32'(bus.par_data), 32'h0000000b);
      chk("bp_hold_valid", 32'(bus.par_valid), 1);
      chk("bp_busy", 32'(bus.busy), 1);
      bit_in(1'b1);
      chk("bp_stable_data", 32'(bus.par_data), 32'h0000000b);
      chk("bp_stable_ready", 32'(bus.sin_ready), 0);
      bus.par_ready = 1'b1;
      idle();
      bus.par_ready = 1'b0;
      chk("bp_next_data", 32'(bus.par_data), 32'h00000006);
      chk("bp_next_valid", 32'(bus.par_valid), 1);
      chk("bp_next_ready", 32'(bus.sin_ready), 1);
      chk("bp_next_busy", 32'(bus.busy), 0);
      bus.par_ready = 1'b1;
      idle();
      chk("bp_drained", 32'(bus.par_valid), 0);

      // gaps between bits
      send(4'b0110, 1'b1);
      chk("gap_valid", 32'(bus.par_valid), 1);
      chk("gap_data", 32'(bus.par_data), 32'h00000006);
      repeat (3) idle();

      // flush drops a simultaneous bit
      bit_in(1'b1);
      bit_in(1'b1);
      chk("flush_pre_busy", 32'(bus.busy), 1);
      bus.flush = 1'b1;
      bit_in(1'b1);
      bus.flush = 1'b0;
      chk("flush_busy", 32'(bus.busy), 0);
      chk("flush_no_frame", 32'(bus.par_valid), 0);
      send(4'b0001, 1'b0);
      chk("flush_data", 32'(bus.par_data), 32'h00000001);
      chk("flush_valid", 32'(bus.par_valid), 1);
      idle();

      // asynchronous reset mid-frame
      bit_in(1'b1);
      bit_in(1'b0);
      bit_in(1'b1);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(bus.busy), 0);
      chk("arst_data", 32'(bus.par_data), 0);
      chk("arst_valid", 32'(bus.par_valid), 0);
      chk("arst_sin_ready", 32'(bus.sin_ready), 1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      send(4'b1100, 1'b0);
      chk("arst_new_data", 32'(bus.par_data), 32'h0000000c);
      chk("arst_new_valid", 32'(bus.par_valid), 1);

      // back-to-back frames at full rate
      for (int k = 0; k < 4; k++) begin
         logic [WIDTH-1:0] f;
         f = WIDTH'($urandom_range(0, 15));
         send(f, 1'b0);
         chk("stream_valid", 32'(bus.par_valid), 1);
         chk("stream_data", 32'(bus.par_data), 32'(f));
      end
      repeat (3) idle();
      chk("sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
